// File: rtl/instr_type_decode.sv
// instr_type_decode
//   IF/ID pipeline stage. Classifies an RV32I instruction word into the
//   one-hot class flags used by the control decoder. It also extracts the
//   register and function fields.
//   A 2-entry (main + skid) buffer keeps full throughput under
//   backpressure. in_ready is registered and does not depend
//   combinationally on out_ready.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   flush               drop every buffered instruction at the next edge
//   in_valid/in_ready   fetch handshake; in_instr, in_pc carry the payload
//   out_valid/out_ready decode handshake toward the control decoder
//   R..aui, illegal     one-hot instruction class of the presented word
//   rd, rs1, rs2, funct3, funct7, imm_raw, pc   extracted fields
//   illegal_cnt         saturating count of illegal words delivered
module instr_type_decode #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             R,
  output logic             I,
  output logic             L,
  output logic             S,
  output logic             B,
  output logic             J,
  output logic             Jr,
  output logic             lui,
  output logic             aui,
  output logic             illegal,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7,
  output logic [24:0]      imm_raw,
  output logic [PC_W-1:0]  pc,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_L   = 7'b0000011;
  localparam logic [6:0] OPC_S   = 7'b0100011;
  localparam logic [6:0] OPC_B   = 7'b1100011;
  localparam logic [6:0] OPC_J   = 7'b1101111;
  localparam logic [6:0] OPC_JR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_AUI = 7'b0010111;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Decoded bundle as held in main/skid. cls bit order: R,I,L,S,B,J,Jr,lui,aui (bit 0 = R)
  typedef struct packed {
    logic            illegal;
    logic [8:0]      cls;
    logic [24:0]     fields;   // instr[31:7]
    logic [PC_W-1:0] pc;
  } bundle_t;

  // {illegal, cls[8:0]}; exactly one bit set
  function automatic logic [9:0] decode_class(input logic [31:0] instr);
    logic [9:0] res;
    res = 10'h200;
    if (instr[1:0] == 2'b11) begin
      case (instr[6:0])
        OPC_R:   res = 10'h001;
        OPC_I:   res = 10'h002;
        OPC_L:   res = 10'h004;
        OPC_S:   res = 10'h008;
        OPC_B:   res = 10'h010;
        OPC_J:   res = 10'h020;
        OPC_JR:  res = 10'h040;
        OPC_LUI: res = 10'h080;
        OPC_AUI: res = 10'h100;
        default: res = 10'h200;
      endcase
    end else begin
      res = 10'h200;
    end
    return res;
  endfunction

  bundle_t          main_r, skid_r, main_s, skid_s, in_bundle_s;
  logic             main_valid_r, skid_valid_r, main_valid_s, skid_valid_s;
  logic             in_ready_r;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [9:0]       in_cls_s;
  logic             in_fire_s, out_fire_s;

  assign in_cls_s           = decode_class(in_instr);
  assign in_bundle_s.illegal = in_cls_s[9];
  assign in_bundle_s.cls     = in_cls_s[8:0];
  assign in_bundle_s.fields  = in_instr[31:7];
  assign in_bundle_s.pc      = in_pc;

  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = main_valid_r & out_ready;

  // Next-state for main/skid buffers and the illegal counter
  always_comb begin
    main_s       = main_r;
    skid_s       = skid_r;
    main_valid_s = main_valid_r;
    skid_valid_s = skid_valid_r;
    cnt_s        = cnt_r;

    // A delivery during flush still counts
    if (out_fire_s && main_r.illegal && (cnt_r != CNT_MAX)) begin
      cnt_s = cnt_r + CNT_ONE;
    end else begin
      cnt_s = cnt_r;
    end

    if (flush) begin
      main_valid_s = 1'b0;
      skid_valid_s = 1'b0;
    end else if (!main_valid_r || out_ready) begin
      // main is free this edge: refill from skid first to keep FIFO order
      if (skid_valid_r) begin
        main_s       = skid_r;
        main_valid_s = 1'b1;
        skid_valid_s = in_fire_s;
        if (in_fire_s) begin
          skid_s = in_bundle_s;
        end else begin
          skid_s = skid_r;
        end
      end else if (in_fire_s) begin
        main_s       = in_bundle_s;
        main_valid_s = 1'b1;
        skid_valid_s = 1'b0;
      end else begin
        main_valid_s = 1'b0;
        skid_valid_s = 1'b0;
      end
    end else begin
      // main stalled: a new word can only land in skid
      if (in_fire_s) begin
        skid_s       = in_bundle_s;
        skid_valid_s = 1'b1;
      end else begin
        skid_valid_s = skid_valid_r;
      end
    end
  end

  // State registers; in_ready tracks the next skid state so it stays registered
  always_ff @(posedge clk) begin
    if (rst) begin
      main_r       <= '0;
      skid_r       <= '0;
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
      cnt_r        <= '0;
    end else begin
      main_r       <= main_s;
      skid_r       <= skid_s;
      main_valid_r <= main_valid_s;
      skid_valid_r <= skid_valid_s;
      in_ready_r   <= ~skid_valid_s;
      cnt_r        <= cnt_s;
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = main_valid_r;
  assign R           = main_r.cls[0];
  assign I           = main_r.cls[1];
  assign L           = main_r.cls[2];
  assign S           = main_r.cls[3];
  assign B           = main_r.cls[4];
  assign J           = main_r.cls[5];
  assign Jr          = main_r.cls[6];
  assign lui         = main_r.cls[7];
  assign aui         = main_r.cls[8];
  assign illegal     = main_r.illegal;
  assign rd          = main_r.fields[4:0];
  assign funct3      = main_r.fields[7:5];
  assign rs1         = main_r.fields[12:8];
  assign rs2         = main_r.fields[17:13];
  assign funct7      = main_r.fields[24:18];
  assign imm_raw     = main_r.fields;
  assign pc          = main_r.pc;
  assign illegal_cnt = cnt_r;

endmodule

// File: tb/tb_instr_type_decode.sv
// Self-checking bench for instr_type_decode. A queue-based reference
// (up to two held words, head = presented word) is stepped on every clock
// and compared against two DUT instances sharing the same stimulus: one
// with a 16-bit counter and one with a 2-bit counter.
module tb_instr_type_decode;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        in_ready, out_valid, R, I, L, S, B, J, Jr, lui, aui, illegal;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [24:0] imm_raw;
  logic [31:0] pc;
  logic [15:0] illegal_cnt;

  logic        s_in_ready, s_out_valid, s_R, s_I, s_L, s_S, s_B, s_J, s_Jr, s_lui, s_aui, s_illegal;
  logic [4:0]  s_rd, s_rs1, s_rs2;
  logic [2:0]  s_funct3;
  logic [6:0]  s_funct7;
  logic [24:0] s_imm_raw;
  logic [31:0] s_pc;
  logic [1:0]  s_cnt;

  instr_type_decode #(.PC_W(32), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .R(R), .I(I), .L(L), .S(S), .B(B), .J(J), .Jr(Jr), .lui(lui), .aui(aui),
    .illegal(illegal), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm_raw(imm_raw), .pc(pc), .illegal_cnt(illegal_cnt)
  );

  instr_type_decode #(.PC_W(32), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(s_out_valid), .out_ready(out_ready),
    .R(s_R), .I(s_I), .L(s_L), .S(s_S), .B(s_B), .J(s_J), .Jr(s_Jr), .lui(s_lui), .aui(s_aui),
    .illegal(s_illegal), .rd(s_rd), .rs1(s_rs1), .rs2(s_rs2), .funct3(s_funct3), .funct7(s_funct7),
    .imm_raw(s_imm_raw), .pc(s_pc), .illegal_cnt(s_cnt)
  );

  logic [8:0] dflags, s_dflags;
  assign dflags   = {aui, lui, Jr, J, B, S, L, I, R};
  assign s_dflags = {s_aui, s_lui, s_Jr, s_J, s_B, s_S, s_L, s_I, s_R};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  logic [31:0] q_instr[$];
  logic [31:0] q_pc[$];
  int unsigned m_cnt16, m_cnt2;

  // Opcodes in class order R, I, L, S, B, J, Jr, lui, aui
  logic [6:0]  opc_tab [0:8] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
  logic [31:0] stream  [0:8] = '{32'h00B50533, 32'h00000013, 32'h0002A283, 32'h00B2A023,
                                 32'hFE000EE3, 32'h0000006F, 32'h00008067, 32'h123452B7,
                                 32'h00001297};

  // Class index 0..8, or 9 for illegal (every listed opcode ends in 2'b11)
  function automatic int ref_class(input logic [31:0] w);
    for (int k = 0; k < 9; k++) begin
      if (w[6:0] == opc_tab[k]) return k;
    end
    return 9;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the reference by one rising edge using the inputs present at that edge
  task automatic model_edge();
    bit infire, outfire;
    if (rst) begin
      q_instr.delete();
      q_pc.delete();
      m_cnt16 = 0;
      m_cnt2  = 0;
    end else begin
      infire  = in_valid && (q_instr.size() < 2);
      outfire = out_ready && (q_instr.size() > 0);
      if (outfire) begin
        if (ref_class(q_instr[0]) == 9) begin
          if (m_cnt16 < 65535) m_cnt16++;
          if (m_cnt2 < 3) m_cnt2++;
        end
        void'(q_instr.pop_front());
        void'(q_pc.pop_front());
      end
      if (flush) begin
        q_instr.delete();
        q_pc.delete();
      end else if (infire) begin
        q_instr.push_back(in_instr);
        q_pc.push_back(in_pc);
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] w;
    int          c;
    logic [8:0]  ef;
    chk("out_valid", out_valid, q_instr.size() > 0);
    chk("in_ready", in_ready, q_instr.size() < 2);
    chk("illegal_cnt16", illegal_cnt, m_cnt16);
    chk("sat_out_valid", s_out_valid, q_instr.size() > 0);
    chk("sat_in_ready", s_in_ready, q_instr.size() < 2);
    chk("illegal_cnt2", s_cnt, m_cnt2);
    if (q_instr.size() > 0) begin
      w  = q_instr[0];
      c  = ref_class(w);
      ef = (c < 9) ? (9'd1 << c) : 9'd0;
      chk("flags", dflags, ef);
      chk("illegal", illegal, c == 9);
      chk("rd", rd, w[11:7]);
      chk("rs1", rs1, w[19:15]);
      chk("rs2", rs2, w[24:20]);
      chk("funct3", funct3, w[14:12]);
      chk("funct7", funct7, w[31:25]);
      chk("imm_raw", imm_raw, w[31:7]);
      chk("pc", pc, q_pc[0]);
      chk("sat_flags", s_dflags, ef);
      chk("sat_illegal", s_illegal, c == 9);
      chk("sat_pc", s_pc, q_pc[0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_in(input logic v, input logic [31:0] w, input logic [31:0] p);
    in_valid = v;
    in_instr = w;
    in_pc    = p;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    set_in(1'b0, 32'h0, 32'h0);
    m_cnt16 = 0; m_cnt2 = 0;

    // Reset
    step();
    step();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_cnt", illegal_cnt, 16'd0);
    chk("rst_flags", {dflags, illegal}, 10'd0);
    chk("rst_pc", pc, 32'd0);
    step();

    // Stream of the nine classes at full rate
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      set_in(1'b1, stream[k], 32'h1000 + 32'(4 * k));
      step();
      chk("stream_flag", dflags, 9'd1 << k);
      chk("stream_pc", pc, 32'h1000 + 32'(4 * k));
      if (k == 0) begin
        chk("add_rd", rd, 5'd10);
        chk("add_rs1", rs1, 5'd10);
        chk("add_rs2", rs2, 5'd11);
      end
    end

    // Illegal words: unknown opcode, then low bits != 2'b11
    set_in(1'b1, 32'h0000007F, 32'h1100);
    step();
    chk("ill1_illegal", illegal, 1'b1);
    chk("ill1_flags", dflags, 9'd0);
    chk("ill1_cnt", illegal_cnt, 16'd0);
    set_in(1'b1, 32'h00000010, 32'h1104);
    step();
    chk("ill2_illegal", illegal, 1'b1);
    chk("ill2_flags", dflags, 9'd0);
    chk("ill2_cnt", illegal_cnt, 16'd1);
    chk("ill2_cnt2", s_cnt, 2'd1);
    set_in(1'b0, 32'h0, 32'h0);
    step();
    chk("ill3_cnt", illegal_cnt, 16'd2);
    chk("ill3_cnt2", s_cnt, 2'd2);

    // Saturation of the 2-bit counter: three more illegal deliveries
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 32'h0000007F, 32'h1200 + 32'(4 * k));
      step();
    end
    chk("sat_c3", s_cnt, 2'd3);
    chk("sat_c16_4", illegal_cnt, 16'd4);
    set_in(1'b0, 32'h0, 32'h0);
    step();
    chk("sat_c3b", s_cnt, 2'd3);
    chk("sat_c16_5", illegal_cnt, 16'd5);

    // Backpressure: A, B accepted, C held off
    out_ready = 1'b0;
    set_in(1'b1, 32'h00000013, 32'h2000);
    step();
    chk("bp_a_pc", pc, 32'h2000);
    chk("bp_a_rdy", in_ready, 1'b1);
    set_in(1'b1, 32'h00B50533, 32'h2004);
    step();
    chk("bp_b_rdy", in_ready, 1'b0);
    set_in(1'b1, 32'h0000006F, 32'h2008);
    step();
    chk("bp_c_rdy", in_ready, 1'b0);
    chk("bp_hold_pc", pc, 32'h2000);
    out_ready = 1'b1;
    step();
    chk("bp_out_b", pc, 32'h2004);
    chk("bp_rdy_back", in_ready, 1'b1);
    step();
    chk("bp_out_c", pc, 32'h2008);
    set_in(1'b0, 32'h0, 32'h0);
    step();
    chk("bp_drained", out_valid, 1'b0);

    // Flush with both entries full and D offered
    out_ready = 1'b0;
    set_in(1'b1, 32'h00000013, 32'h3000);
    step();
    set_in(1'b1, 32'h00000013, 32'h3004);
    step();
    flush = 1'b1;
    set_in(1'b1, 32'h00008067, 32'h3008);
    step();
    chk("fl_out_valid", out_valid, 1'b0);
    chk("fl_in_ready", in_ready, 1'b1);
    flush = 1'b0; out_ready = 1'b1;
    set_in(1'b1, 32'h123452B7, 32'h300C);
    step();
    chk("fl_e_pc", pc, 32'h300C);
    chk("fl_e_lui", lui, 1'b1);
    set_in(1'b0, 32'h0, 32'h0);
    step();
    chk("fl_no_d", out_valid, 1'b0);

    // Reset with both entries full
    out_ready = 1'b0;
    set_in(1'b1, 32'h0000007F, 32'h4000);
    step();
    set_in(1'b1, 32'h00000013, 32'h4004);
    step();
    rst = 1'b1;
    step();
    chk("mr_out_valid", out_valid, 1'b0);
    chk("mr_cnt", illegal_cnt, 16'd0);
    chk("mr_cnt2", s_cnt, 2'd0);
    rst = 1'b0;
    set_in(1'b0, 32'h0, 32'h0);
    step();
    chk("mr_in_ready", in_ready, 1'b1);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w[6:0] = opc_tab[$urandom_range(0, 8)];
      set_in($urandom_range(0, 9) < 7, w, $urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 5);
      rst       = ($urandom_range(0, 99) < 2);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
